// File: rtl/alu_execute_stage.sv
// alu_execute_stage -- execute stage: operand-B select, combinational alu,
// and a 2-entry skid buffer carrying {result, rd, reg_write} downstream.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   in_valid / in_ready        decode handshake (in_ready is ~skid_v, no path from out_ready)
//   in_op, in_sub              alu op (funct3) and sub / arithmetic-shift select
//   in_use_imm                 1: B = in_imm, 0: B = rs2 operand
//   in_rs1_val, in_rs2_val     register-file operands
//   in_imm                     sign-extended immediate
//   in_rs1_addr, in_rs2_addr   source indices (used only for forwarding)
//   in_rd, in_reg_write        destination; rd==0 clears the write enable
//   out_valid / out_ready      downstream handshake
//   out_result, out_rd,
//   out_reg_write              always driven from the main entry
//
// Build option
//   EX_FORWARD_EN  when defined, rs1/rs2 operands are replaced by the youngest
//                  buffered result writing that register (skid over main).

module alu_core #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic            sub,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  logic [4:0]        shamt;
  logic [XLEN:0]     diff;
  logic              ltu, lts;
  logic [2*XLEN-1:0] sh_ext;
  logic [2*XLEN-1:0] sh_r;

  assign shamt  = b[4:0];
  assign diff   = {1'b0, a} - {1'b0, b};
  assign ltu    = diff[XLEN];
  // differing signs: the negative one is smaller; same signs: unsigned order holds
  assign lts    = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : ltu;
  // one right shifter for both srl and sra: fill the upper half with the sign when sub=1
  assign sh_ext = {{XLEN{sub & a[XLEN-1]}}, a};
  assign sh_r   = sh_ext >> shamt;

  always_comb begin
    y = '0;
    case (op)
      3'b000: y = sub ? diff[XLEN-1:0] : a + b;
      3'b001: y = a << shamt;
      3'b010: y = {{(XLEN-1){1'b0}}, lts};
      3'b011: y = {{(XLEN-1){1'b0}}, ltu};
      3'b100: y = a ^ b;
      3'b101: y = sh_r[XLEN-1:0];
      3'b110: y = a | b;
      default: y = a & b;
    endcase
  end
endmodule

module alu_execute_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic                  in_sub,
  input  logic                  in_use_imm,
  input  logic [XLEN-1:0]       in_rs1_val,
  input  logic [XLEN-1:0]       in_rs2_val,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write
);
  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } ent_t;

  ent_t            main_q, skid_q, new_e;
  logic            main_v, skid_v;
  logic            accept, push;
  logic [XLEN-1:0] op_a, op_rs2, op_b, alu_y;

  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;
  assign push     = main_v & out_ready;

`ifdef EX_FORWARD_EN
  always_comb begin
    op_a   = in_rs1_val;
    op_rs2 = in_rs2_val;
    if (in_rs1_addr != '0) begin
      if (skid_v && skid_q.reg_write && skid_q.rd == in_rs1_addr)
        op_a = skid_q.result;
      else if (main_v && main_q.reg_write && main_q.rd == in_rs1_addr)
        op_a = main_q.result;
    end
    if (!in_use_imm && in_rs2_addr != '0) begin
      if (skid_v && skid_q.reg_write && skid_q.rd == in_rs2_addr)
        op_rs2 = skid_q.result;
      else if (main_v && main_q.reg_write && main_q.rd == in_rs2_addr)
        op_rs2 = main_q.result;
    end
  end
`else
  logic unused_addr;
  assign unused_addr = ^{in_rs1_addr, in_rs2_addr};
  assign op_a   = in_rs1_val;
  assign op_rs2 = in_rs2_val;
`endif

  assign op_b = in_use_imm ? in_imm : op_rs2;

  alu_core #(.XLEN(XLEN)) u_alu (
    .op  (in_op),
    .sub (in_sub),
    .a   (op_a),
    .b   (op_b),
    .y   (alu_y)
  );

  // x0 is never written, so drop the enable at capture
  assign new_e.result    = alu_y;
  assign new_e.rd        = in_rd;
  assign new_e.reg_write = in_reg_write & (in_rd != '0);

  // {main_v, skid_v}: 00 empty, 10 one entry, 11 full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case ({main_v, skid_v})
        2'b00: begin
          if (accept) begin
            main_q <= new_e;
            main_v <= 1'b1;
          end
        end
        2'b10: begin
          if (accept && push) begin
            main_q <= new_e;
          end else if (accept) begin
            skid_q <= new_e;
            skid_v <= 1'b1;
          end else if (push) begin
            main_v <= 1'b0;
          end
        end
        default: begin
          // full: in_ready is low, only a drain can happen
          if (push) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_valid     = main_v;
  assign out_result    = main_q.result;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.reg_write;
endmodule

// File: tb/tb_alu_execute_stage.sv
module tb_alu_execute_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic        in_sub, in_use_imm;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
  logic        in_reg_write;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  always #5 clk = ~clk;

  alu_execute_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_sub(in_sub), .in_use_imm(in_use_imm),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference: ordered list of results still owed downstream, at most 2 deep
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
  } ent_t;
  ent_t q[$];

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic sub,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return sub ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return sub ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // youngest owed result that writes this register; otherwise the register-file value
  function automatic logic [31:0] operand(input logic [4:0] addr, input logic [31:0] rf);
`ifdef EX_FORWARD_EN
    if (addr != 0)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].rw && q[i].rd == addr) return q[i].res;
`endif
    return rf;
  endfunction

  task automatic model_check();
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].res);
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
      chk("out_reg_write", 32'(out_reg_write), 32'(q[0].rw));
    end
  endtask

  task automatic model_update();
    ent_t e;
    logic acc, psh;
    logic [31:0] a, b;
    acc = in_valid && (q.size() < 2);
    psh = (q.size() > 0) && out_ready;
    a = operand(in_rs1_addr, in_rs1_val);
    b = in_use_imm ? in_imm : operand(in_rs2_addr, in_rs2_val);
    e.res = ref_alu(in_op, in_sub, a, b);
    e.rd  = in_rd;
    e.rw  = in_reg_write && (in_rd != 0);
    if (psh) void'(q.pop_front());
    if (acc) q.push_back(e);
  endtask

  // one cycle: check against model, drive, clock, advance model; ends just after the edge
  task automatic step(input logic v, input logic [2:0] op, input logic sub, input logic ui,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                      input logic rw, input logic ordy);
    @(negedge clk);
    model_check();
    in_valid = v; in_op = op; in_sub = sub; in_use_imm = ui;
    in_rs1_val = r1; in_rs2_val = r2; in_imm = im;
    in_rs1_addr = a1; in_rs2_addr = a2; in_rd = d; in_reg_write = rw;
    out_ready = ordy;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1'b0, ordy);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_op = 0; in_sub = 0; in_use_imm = 0;
    in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_rd = 0; in_reg_write = 0; out_ready = 0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_rd", 32'(out_rd), 0);
    chk("rst_out_reg_write", 32'(out_reg_write), 0);
    @(negedge clk); reset = 1'b0;

    // add / sub
    step(1, 3'd0, 0, 0, 5, 7, 0, 0, 0, 5'd1, 1, 1);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_5_7", out_result, 32'd12);
    step(1, 3'd0, 1, 0, 5, 7, 0, 0, 0, 5'd1, 1, 1);
    chk("sub_5_7", out_result, 32'hFFFF_FFFE);
    idle(1);

    // back-pressure: fill both entries, hold the third, then drain in order
    step(1, 3'd0, 0, 0, 1, 1, 0, 0, 0, 5'd2, 1, 0);
    chk("bp_ready_1", 32'(in_ready), 1);
    step(1, 3'd0, 0, 0, 2, 2, 0, 0, 0, 5'd2, 1, 0);
    chk("bp_ready_2", 32'(in_ready), 0);
    step(1, 3'd0, 0, 0, 3, 3, 0, 0, 0, 5'd2, 1, 0);
    chk("bp_hold", out_result, 32'd2);
    step(1, 3'd0, 0, 0, 3, 3, 0, 0, 0, 5'd2, 1, 1);
    chk("bp_drain_4", out_result, 32'd4);
    chk("bp_ready_3", 32'(in_ready), 1);
    step(1, 3'd0, 0, 0, 3, 3, 0, 0, 0, 5'd2, 1, 1);
    chk("bp_drain_6", out_result, 32'd6);
    idle(1);
    chk("bp_empty", 32'(out_valid), 0);

    // immediate shifts
    step(1, 3'd5, 1, 1, 32'hF000_0000, 32'hFFFF_FFFF, 32'd4, 0, 0, 5'd3, 1, 1);
    chk("srai", out_result, 32'hFF00_0000);
    step(1, 3'd5, 0, 1, 32'hF000_0000, 32'hFFFF_FFFF, 32'd4, 0, 0, 5'd3, 1, 1);
    chk("srli", out_result, 32'h0F00_0000);

    // rd=0 suppresses write enable
    step(1, 3'd0, 0, 0, 1, 2, 0, 0, 0, 5'd0, 1, 1);
    chk("rd0_rw", 32'(out_reg_write), 0);
    step(1, 3'd0, 0, 0, 1, 2, 0, 0, 0, 5'd3, 1, 1);
    chk("rd3_rw", 32'(out_reg_write), 1);
    chk("rd3_rd", 32'(out_rd), 3);
    idle(1);

    // forwarding from a buffered result
    step(1, 3'd0, 0, 0, 10, 2, 0, 0, 0, 5'd5, 1, 0);
    step(1, 3'd0, 0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd6, 1, 0);
    idle(1);
`ifdef EX_FORWARD_EN
    chk("fwd_rs1", out_result, 32'd13);
`else
    chk("nofwd_rs1", out_result, 32'd1);
`endif
    idle(1);
    step(1, 3'd0, 0, 0, 10, 2, 0, 0, 0, 5'd0, 1, 0);
    step(1, 3'd0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd6, 1, 0);
    idle(1);
    chk("fwd_x0", out_result, 32'd1);
    idle(1);

    // reset while full clears outputs immediately
    step(1, 3'd0, 0, 0, 4, 4, 0, 0, 0, 5'd7, 1, 0);
    step(1, 3'd0, 0, 0, 8, 8, 0, 0, 0, 5'd7, 1, 0);
    in_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    chk("mid_rst_result", out_result, 0);
    q.delete();
    @(negedge clk); reset = 1'b0;

    // randomized traffic with small register indices so forwarding hazards occur
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r1, r2, im;
      r1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      im = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), r1, r2, im,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0);
    end
    idle(1);
    idle(1);
    @(negedge clk);
    model_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
